// File: rtl/mem_stage_pkg.sv
// Shared widths, exception codes, load-type bit order and bus payload layouts for the MEM stage.
package mem_stage_pkg;

   localparam int unsigned ES_TO_MS_BUS_WD = 96;
   localparam int unsigned MS_TO_WS_BUS_WD = 91;
   localparam int unsigned MS_FWD_BUS_WD   = 40;
   localparam int unsigned C0_BUS_WD       = 11;
   localparam int unsigned LD_INST_WD      = 7;
   localparam int unsigned C0_MFC0_BIT     = 8;

   // Bit positions inside ld_inst, msb first: lw,lb,lbu,lh,lhu,lwl,lwr
   localparam int unsigned LD_LW  = 6;
   localparam int unsigned LD_LB  = 5;
   localparam int unsigned LD_LBU = 4;
   localparam int unsigned LD_LH  = 3;
   localparam int unsigned LD_LHU = 2;
   localparam int unsigned LD_LWL = 1;
   localparam int unsigned LD_LWR = 0;

   localparam logic [4:0] EX_INT  = 5'h00;
   localparam logic [4:0] EX_ADEL = 5'h04;
   localparam logic [4:0] EX_ADES = 5'h05;
   localparam logic [4:0] EX_SYS  = 5'h08;
   localparam logic [4:0] EX_BP   = 5'h09;
   localparam logic [4:0] EX_RI   = 5'h0a;
   localparam logic [4:0] EX_OV   = 5'h0c;

   typedef struct packed {
      logic [C0_BUS_WD-1:0]  c0_bus;
      logic                  bd;
      logic                  ex;
      logic [4:0]            excode;
      logic [LD_INST_WD-1:0] ld_inst;
      logic                  res_from_mem;
      logic                  gr_we;
      logic [4:0]            dest;
      logic [31:0]           res;
      logic [31:0]           pc;
   } es_to_ms_t;

   typedef struct packed {
      logic [C0_BUS_WD-1:0] c0_bus;
      logic                 bd;
      logic                 ex;
      logic [4:0]           excode;
      logic [3:0]           rf_we;
      logic [4:0]           dest;
      logic [31:0]          final_result;
      logic [31:0]          pc;
   } ms_to_ws_t;

   typedef struct packed {
      logic        no_fwd;
      logic        mfc0_valid;
      logic        block_valid;
      logic [4:0]  dest;
      logic [31:0] result;
   } ms_fwd_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: byte/half select with sign/zero extension and lwl/lwr byte merge enables.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [LD_INST_WD-1:0] i_ld_inst,
   input  logic [1:0]            i_off,
   input  logic [31:0]           i_rdata,
   output logic [31:0]           o_data,
   output logic [3:0]            o_rf_we
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_data  = i_rdata;
      o_rf_we = 4'b1111;
      if (i_ld_inst[LD_LW]) begin
         o_data = i_rdata;
      end else if (i_ld_inst[LD_LB]) begin
         o_data = {{24{w_byte[7]}}, w_byte};
      end else if (i_ld_inst[LD_LBU]) begin
         o_data = {24'd0, w_byte};
      end else if (i_ld_inst[LD_LH]) begin
         o_data = {{16{w_half[15]}}, w_half};
      end else if (i_ld_inst[LD_LHU]) begin
         o_data = {16'd0, w_half};
      end else if (i_ld_inst[LD_LWL]) begin
         // lwl fills the register from the top byte down
         case (i_off)
            2'd0: begin o_data = {i_rdata[7:0],  24'd0}; o_rf_we = 4'b1000; end
            2'd1: begin o_data = {i_rdata[15:0], 16'd0}; o_rf_we = 4'b1100; end
            2'd2: begin o_data = {i_rdata[23:0], 8'd0};  o_rf_we = 4'b1110; end
            default: begin o_data = i_rdata;             o_rf_we = 4'b1111; end
         endcase
      end else if (i_ld_inst[LD_LWR]) begin
         case (i_off)
            2'd0: begin o_data = i_rdata;                o_rf_we = 4'b1111; end
            2'd1: begin o_data = {8'd0,  i_rdata[31:8]}; o_rf_we = 4'b0111; end
            2'd2: begin o_data = {16'd0, i_rdata[31:16]}; o_rf_we = 4'b0011; end
            default: begin o_data = {24'd0, i_rdata[31:24]}; o_rf_we = 4'b0001; end
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX result, aligns load data and drives writeback and forwarding buses.
// Optional feature macro MS_FWD_LOAD_EN: forward aligned load results (except lwl/lwr) straight from MEM.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
   output logic                       ms_ex,
   input  logic                       flush
);

   logic        r_ms_valid;
   logic        r_first_cycle;
   es_to_ms_t   r_bus;
   logic [31:0] r_rdata;

   logic        w_capture;
   logic [31:0] w_rdata;
   logic [31:0] w_ld_data;
   logic [3:0]  w_ld_we;
   logic        w_no_fwd;
   ms_to_ws_t   w_ws;
   ms_fwd_t     w_fwd;

   assign ms_allowin = !r_ms_valid || ws_allowin;
   assign w_capture  = es_to_ms_valid && ms_allowin;

   // SRAM data is only live in the first MEM cycle; keep a copy for stalls
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ms_valid    <= 1'b0;
         r_first_cycle <= 1'b0;
         r_bus         <= '0;
         r_rdata       <= 32'd0;
      end else begin
         if (flush) begin
            r_ms_valid <= 1'b0;
         end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
         end
         if (w_capture) begin
            r_bus <= es_to_ms_t'(es_to_ms_bus);
         end
         if (r_first_cycle) begin
            r_rdata <= data_sram_rdata;
         end
         r_first_cycle <= w_capture && !flush;
      end
   end

   assign w_rdata = r_first_cycle ? data_sram_rdata : r_rdata;

   mem_stage_load_align u_load_align (
      .i_ld_inst (r_bus.ld_inst),
      .i_off     (r_bus.res[1:0]),
      .i_rdata   (w_rdata),
      .o_data    (w_ld_data),
      .o_rf_we   (w_ld_we)
   );

`ifdef MS_FWD_LOAD_EN
   assign w_no_fwd = r_bus.res_from_mem && (r_bus.ld_inst[LD_LWL] || r_bus.ld_inst[LD_LWR]);
`else
   assign w_no_fwd = r_bus.res_from_mem;
`endif

   always_comb begin
      w_ws.c0_bus       = r_bus.c0_bus;
      w_ws.bd           = r_bus.bd;
      w_ws.ex           = r_bus.ex;
      w_ws.excode       = r_bus.excode;
      w_ws.dest         = r_bus.dest;
      w_ws.pc           = r_bus.pc;
      w_ws.final_result = r_bus.res;
      w_ws.rf_we        = {4{r_bus.gr_we}};
      // Excepting instructions keep res (the bad address) and write nothing
      if (r_bus.ex) begin
         w_ws.rf_we = 4'b0000;
      end else if (r_bus.res_from_mem) begin
         w_ws.final_result = w_ld_data;
         w_ws.rf_we        = w_ld_we;
      end
   end

   always_comb begin
      w_fwd.no_fwd      = r_ms_valid && w_no_fwd;
      w_fwd.mfc0_valid  = r_ms_valid && r_bus.c0_bus[C0_MFC0_BIT];
      w_fwd.block_valid = r_ms_valid && r_bus.gr_we && !r_bus.ex && !flush;
      w_fwd.dest        = r_bus.dest;
      w_fwd.result      = w_ws.final_result;
   end

   assign ms_to_ws_valid = r_ms_valid && !flush;
   assign ms_ex          = r_ms_valid && r_bus.ex && !flush;
   assign ms_to_ws_bus   = w_ws;
   assign ms_fwd_bus     = w_fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/exception/flush/reset cases plus random traffic vs a reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [95:0] es_to_ms_bus;
   logic [31:0] data_sram_rdata;
   logic        ms_to_ws_valid;
   logic [90:0] ms_to_ws_bus;
   logic [39:0] ms_fwd_bus;
   logic        ms_ex;
   logic        flush;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: the instruction sitting in MEM and the SRAM word it saw first
   logic        m_valid = 1'b0;
   logic        m_first = 1'b0;
   logic [95:0] m_ins   = '0;
   logic [31:0] m_held  = '0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_rdata (data_sram_rdata),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_fwd_bus      (ms_fwd_bus),
      .ms_ex           (ms_ex),
      .flush           (flush)
   );

   function automatic logic [95:0] mk_bus(input logic [10:0] c0, input logic bd, input logic ex,
                                          input logic [4:0] excode, input logic [6:0] ld,
                                          input logic rfm, input logic gr_we, input logic [4:0] dest,
                                          input logic [31:0] res, input logic [31:0] pc);
      return {c0, bd, ex, excode, ld, rfm, gr_we, dest, res, pc};
   endfunction

   // ld one-hot: [6]=lw [5]=lb [4]=lbu [3]=lh [2]=lhu [1]=lwl [0]=lwr
   function automatic void ref_load(input logic [6:0] ld, input logic [1:0] off, input logic [31:0] d,
                                    output logic [31:0] val, output logic [3:0] we);
      logic [31:0] b;
      logic [31:0] h;
      b   = (d >> (8 * off)) & 32'hFF;
      h   = (d >> (16 * off[1])) & 32'hFFFF;
      val = d;
      we  = 4'b1111;
      if (ld[5])      val = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      else if (ld[4]) val = b;
      else if (ld[3]) val = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      else if (ld[2]) val = h;
      else if (ld[1]) begin
         val = d << (8 * (3 - off));
         we  = 4'(((32'd1 << (off + 1)) - 32'd1) << (3 - off));
      end else if (ld[0]) begin
         val = d >> (8 * off);
         we  = 4'((32'd1 << (4 - off)) - 32'd1);
      end
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic esv, input logic [95:0] bus, input logic [31:0] rd,
                        input logic wsa, input logic fl);
      @(negedge clk);
      reset           = rst;
      es_to_ms_valid  = esv;
      es_to_ms_bus    = bus;
      data_sram_rdata = rd;
      ws_allowin      = wsa;
      flush           = fl;
      #1;
   endtask

   task automatic check_model();
      logic [31:0] rd;
      logic [31:0] val;
      logic [3:0]  we;
      logic        ex;
      logic        rfm;
      logic        gr_we;
      logic        nofwd;
      logic [6:0]  ld;
      logic [90:0] exp_ws;
      ex    = m_ins[83];
      ld    = m_ins[77:71];
      rfm   = m_ins[70];
      gr_we = m_ins[69];
      rd    = m_first ? data_sram_rdata : m_held;
      if (ex) begin
         val = m_ins[63:32];
         we  = 4'b0000;
      end else if (rfm) begin
         ref_load(ld, m_ins[33:32], rd, val, we);
      end else begin
         val = m_ins[63:32];
         we  = {4{gr_we}};
      end
`ifdef MS_FWD_LOAD_EN
      nofwd = m_valid && rfm && (ld[1] || ld[0]);
`else
      nofwd = m_valid && rfm;
`endif
      exp_ws = {m_ins[95:84], ex, m_ins[82:78], we, m_ins[68:64], val, m_ins[31:0]};
      chk("allowin",  96'(ms_allowin),     96'(!m_valid || ws_allowin));
      chk("ws_valid", 96'(ms_to_ws_valid), 96'(m_valid && !flush));
      chk("ms_ex",    96'(ms_ex),          96'(m_valid && ex && !flush));
      chk("fwd_ctl",  96'(ms_fwd_bus[39:37]),
          96'({nofwd, m_valid && m_ins[93], m_valid && gr_we && !ex && !flush}));
      if (m_valid) begin
         chk("ws_bus",   96'(ms_to_ws_bus),      96'(exp_ws));
         chk("fwd_data", 96'(ms_fwd_bus[36:0]),  96'({m_ins[68:64], val}));
      end
   endtask

   task automatic tick();
      logic        allow;
      logic        cap;
      logic        n_valid;
      logic        n_first;
      logic [95:0] n_ins;
      logic [31:0] n_held;
      if (reset) begin
         n_valid = 1'b0;
         n_first = 1'b0;
         n_ins   = '0;
         n_held  = '0;
      end else begin
         allow   = !m_valid || ws_allowin;
         cap     = es_to_ms_valid && allow;
         n_held  = m_first ? data_sram_rdata : m_held;
         n_ins   = cap ? es_to_ms_bus : m_ins;
         n_valid = flush ? 1'b0 : (allow ? es_to_ms_valid : m_valid);
         n_first = cap && !flush;
      end
      @(posedge clk);
      m_valid = n_valid;
      m_first = n_first;
      m_ins   = n_ins;
      m_held  = n_held;
   endtask

   task automatic step(input logic rst, input logic esv, input logic [95:0] bus, input logic [31:0] rd,
                       input logic wsa, input logic fl);
      drive(rst, esv, bus, rd, wsa, fl);
      check_model();
      tick();
   endtask

   initial begin
      logic [95:0] b;
      logic        rfm;
      logic [6:0]  ld;

      reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
      data_sram_rdata = '0; ws_allowin = 1'b1; flush = 1'b0;
      drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0); tick();
      drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0); tick();

      // Reset state
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      check_model();
      chk("rst_allowin",  96'(ms_allowin),        96'(1'b1));
      chk("rst_ws_valid", 96'(ms_to_ws_valid),    96'(1'b0));
      chk("rst_fwd_ctl",  96'(ms_fwd_bus[39:37]), 96'(3'b000));
      tick();

      // lb, sign extension of the top byte
      b = mk_bus(11'd0, 1'b0, 1'b0, 5'd0, 7'b0100000, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'hBFC0_0100);
      step(1'b0, 1'b1, b, '0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, '0, 32'h80FF_1234, 1'b1, 1'b0);
      check_model();
      chk("lb_result", 96'(ms_to_ws_bus[63:32]), 96'(32'hFFFF_FF80));
      chk("lb_rf_we",  96'(ms_to_ws_bus[72:69]), 96'(4'b1111));
      chk("lb_valid",  96'(ms_to_ws_valid),      96'(1'b1));
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      check_model();
      chk("lb_gone", 96'(ms_to_ws_valid), 96'(1'b0));
      tick();

      // lhu upper half, zero extended
      b = mk_bus(11'd0, 1'b0, 1'b0, 5'd0, 7'b0000100, 1'b1, 1'b1, 5'd4, 32'h0000_1002, 32'hBFC0_0104);
      step(1'b0, 1'b1, b, '0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, '0, 32'h8001_0000, 1'b1, 1'b0);
      check_model();
      chk("lhu_result", 96'(ms_to_ws_bus[63:32]), 96'(32'h0000_8001));
      tick();

      // lwl off=1, then lwr off=2 back to back
      b = mk_bus(11'd0, 1'b0, 1'b0, 5'd5, 7'b0000010, 1'b1, 1'b1, 5'd5, 32'h0000_1001, 32'hBFC0_0108);
      step(1'b0, 1'b1, b, '0, 1'b1, 1'b0);
      b = mk_bus(11'd0, 1'b0, 1'b0, 5'd0, 7'b0000001, 1'b1, 1'b1, 5'd6, 32'h0000_1002, 32'hBFC0_010C);
      drive(1'b0, 1'b1, b, 32'hAABB_CCDD, 1'b1, 1'b0);
      check_model();
      chk("lwl_hi",     96'(ms_to_ws_bus[63:48]), 96'(16'hCCDD));
      chk("lwl_rf_we",  96'(ms_to_ws_bus[72:69]), 96'(4'b1100));
      chk("lwl_no_fwd", 96'(ms_fwd_bus[39]),      96'(1'b1));
      tick();
      drive(1'b0, 1'b0, '0, 32'hAABB_CCDD, 1'b1, 1'b0);
      check_model();
      chk("lwr_lo",    96'(ms_to_ws_bus[47:32]), 96'(16'hAABB));
      chk("lwr_rf_we", 96'(ms_to_ws_bus[72:69]), 96'(4'b0011));
      tick();

      // lw held across a 3-cycle writeback stall while SRAM data changes
      b = mk_bus(11'd0, 1'b0, 1'b0, 5'd0, 7'b1000000, 1'b1, 1'b1, 5'd7, 32'h0000_2000, 32'hBFC0_0110);
      step(1'b0, 1'b1, b, '0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, '0, 32'h1234_5678, 1'b0, 1'b0);
      check_model();
      chk("stall_allowin", 96'(ms_allowin), 96'(1'b0));
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
         check_model();
         chk("stall_hold", 96'(ms_to_ws_bus[63:32]), 96'(32'h1234_5678));
         tick();
      end
      drive(1'b0, 1'b0, '0, 32'hDEAD_BEEF, 1'b1, 1'b0);
      check_model();
      chk("stall_release", 96'(ms_to_ws_bus[63:32]), 96'(32'h1234_5678));
      chk("stall_valid",   96'(ms_to_ws_valid),      96'(1'b1));
      tick();

      // AdEL exception keeps the bad address and writes nothing
      b = mk_bus(11'd0, 1'b0, 1'b1, 5'h04, 7'b1000000, 1'b1, 1'b1, 5'd8, 32'h0000_1001, 32'hBFC0_0114);
      step(1'b0, 1'b1, b, '0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, '0, 32'h5555_AAAA, 1'b1, 1'b0);
      check_model();
      chk("ex_ms_ex",  96'(ms_ex),                96'(1'b1));
      chk("ex_rf_we",  96'(ms_to_ws_bus[72:69]), 96'(4'b0000));
      chk("ex_result", 96'(ms_to_ws_bus[63:32]), 96'(32'h0000_1001));
      chk("ex_block",  96'(ms_fwd_bus[37]),       96'(1'b0));
      tick();

      // Flush with a valid lw in MEM and a new instruction arriving
      b = mk_bus(11'd0, 1'b0, 1'b0, 5'd0, 7'b1000000, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'hBFC0_0118);
      step(1'b0, 1'b1, b, '0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, b, 32'h0BAD_F00D, 1'b1, 1'b1);
      check_model();
      chk("flush_ws_valid", 96'(ms_to_ws_valid), 96'(1'b0));
      tick();
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      check_model();
      chk("flush_after", 96'(ms_to_ws_valid), 96'(1'b0));
      tick();

      // Reset while stalled
      step(1'b0, 1'b1, b, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 32'h7777_8888, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 32'h7777_8888, 1'b0, 1'b0);
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      check_model();
      chk("rst2_ws_valid", 96'(ms_to_ws_valid),    96'(1'b0));
      chk("rst2_allowin",  96'(ms_allowin),        96'(1'b1));
      chk("rst2_fwd_ctl",  96'(ms_fwd_bus[39:37]), 96'(3'b000));
      chk("rst2_bus",      96'(ms_to_ws_bus),      96'(0));
      tick();

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         rfm = 1'($urandom_range(1, 0));
         ld  = rfm ? 7'(7'd1 << $urandom_range(6, 0)) : 7'd0;
         b   = mk_bus(11'($urandom), 1'($urandom), ($urandom_range(7, 0) == 0), 5'($urandom),
                      ld, rfm, rfm ? 1'b1 : 1'($urandom), 5'($urandom), $urandom, $urandom);
         step(($urandom_range(63, 0) == 0), ($urandom_range(3, 0) != 0), b, $urandom,
              ($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage, directly downstream of the execute stage; consumes es_to_ms_bus and the synchronous data-SRAM read data.
- Performs load-data extraction: byte/half select, sign/zero extension, lwl/lwr byte-merge enables.
- Produces ms_to_ws_bus for writeback, a forward bus for decode, and ms_ex, which upstream uses to suppress side effects of younger instructions.

Parameters:
- None; bus widths come from mycpu.h macros: ES_TO_MS_BUS_WD=96, MS_TO_WS_BUS_WD=91, MS_FWD_BUS_WD=40.

Ports:
- clk  in  1  clock; single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- ws_allowin  in  1  writeback can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  upstream valid.
- es_to_ms_bus  in  96  {c0_bus[95:85], bd[84], ex[83], excode[82:78], ld_inst[77:71] = lw,lb,lbu,lh,lhu,lwl,lwr, res_from_mem[70], gr_we[69], dest[68:64], res[63:32], pc[31:0]}.
- data_sram_rdata  in  32  read data for the access issued by EX in the previous cycle.
- ms_to_ws_valid  out  1  valid to writeback.
- ms_to_ws_bus  out  91  {c0_bus[90:80], bd[79], ex[78], excode[77:73], rf_we[72:69], dest[68:64], final_result[63:32], pc[31:0]}.
- ms_fwd_bus  out  40  {no_fwd[39], mfc0_valid[38], block_valid[37], dest[36:32], result[31:0]}.
- ms_ex  out  1  valid instruction in MS carries an exception.
- flush  in  1  exception/eret flush from writeback.

Behaviour:
- Reset:
  - ms_valid=0; bus register=0; rdata_held=0.
  - Outputs: ms_to_ws_valid=0, ms_allowin=1, ms_ex=0, fwd bits 39:37 = 0.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid && !flush.
  - Bus register captured when es_to_ms_valid && ms_allowin.
  - ms_valid <= es_to_ms_valid when ms_allowin.
- Flush: ms_valid <= 0 at the next edge, overriding the capture. ms_to_ws_valid and ms_ex are 0 in the flush cycle.
- Read-data hold (sequential requirement): SRAM output is valid only in the first MS cycle of an instruction.
  - On the first valid cycle (first_cycle flag, set on capture), latch data_sram_rdata into rdata_r.
  - While stalled (ms_valid && !ws_allowin), extraction uses rdata_r.
  - Live rdata is used only in the first cycle.
  - first_cycle clears after one cycle, or on reset or flush.
- Extraction (off = res[1:0]):
  - lw: data=rdata, rf_we=1111.
  - lb/lbu: byte[off], sign/zero-extended, 1111.
  - lh/lhu: half[off[1]], sign/zero-extended, 1111.
  - lwl: data = rdata << 8*(3-off); rf_we = 1000, 1100, 1110, 1111 for off = 0..3.
  - lwr: data = rdata >> 8*off; rf_we = 1111, 0111, 0011, 0001 for off = 0..3.
- Result selection:
  - res_from_mem=0: final_result=res, rf_we={4{gr_we}}.
  - ex=1: rf_we=0000 and final_result=res, which is the bad address for AdEL/AdES.
- ms_ex = ms_valid && ex.
- Forward bus:
  - block_valid = ms_valid && gr_we && !ex && !flush.
  - mfc0_valid = ms_valid && c0_bus[8].
  - no_fwd=1 for lwl/lwr (partial write, not forwardable).
  - result = final_result.
- Back-to-back: capture of the next instruction and hand-off of the current one occur on the same edge when ws_allowin=1.

Optional Feature:
- Macro MS_FWD_LOAD_EN.
- Defined: load results are forwarded from MS with no_fwd=0, except lwl/lwr.
- Undefined: no_fwd=1 for every load, so decode stalls until writeback. This removes the extraction path from the forward timing path.

Decomposition:
- Shared in mycpu.h: ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_FWD_BUS_WD, EX_* excode constants, and the ld_inst bit-order constants.
- One natural sub-module: load_align, purely combinational. Inputs: ld_inst, off, rdata. Outputs: data and rf_we.

Test Plan:
- lb, res=0x1003, rdata=0x80FF_1234 → final_result=0xFFFF_FF80, rf_we=1111, one cycle to WS.
- lhu, res=0x1002, rdata=0x8001_0000 → 0x0000_8001.
- lwl off=1, rdata=0xAABB_CCDD → data[31:16]=0xCCDD, rf_we=1100, no_fwd=1. lwr off=2 → data[15:0]=0xAABB, rf_we=0011.
- lw, ws_allowin=0 for 3 cycles, rdata changed to 0xDEAD_BEEF after the first cycle → output stays at the first-cycle value 0x1234_5678, delivered when ws_allowin=1.
- ex=1, excode=EX_ADEL, res=0x1001 → ms_ex=1, rf_we=0000, final_result=0x1001, block_valid=0.
- flush asserted with a valid lw in MS plus an incoming instruction → ms_to_ws_valid=0 that cycle, ms_valid=0 next cycle. Reset mid-stall → all outputs return to reset values on the next edge.
